// File: rtl/token_renderer.sv
// token_renderer
//
// Moves the two player tokens on the VGA frame buffer. It compares each
// player's target box with the box it last drew. On a change it erases the
// old box with the board colour and then draws the new box in the player
// colour. Both players share one pixel port, and P1 is served first. If an
// erase uncovers part of the other player's token, that token is queued to
// be drawn again.
//
// Ports
//   clk         system clock
//   resetn      asynchronous active-low reset
//   p1_x/p1_y   P1 token top-left corner
//   p2_x/p2_y   P2 token top-left corner (P2_Y_OFFSET is added internally)
//   redraw_all  single-cycle request to redraw both tokens
//   x/y/colour  pixel coordinate and colour to the vga_adapter
//   plot        pixel write strobe
//   busy        high while a service is in progress
//   done        one-cycle pulse after a token draw completes

module token_renderer #(
    parameter int unsigned TOKEN_SZ    = 3,
    parameter logic [2:0]  P1_COLOUR   = 3'b001,
    parameter logic [2:0]  P2_COLOUR   = 3'b011,
    parameter logic [2:0]  BG_COLOUR   = 3'b111,
    parameter int unsigned P2_Y_OFFSET = 15
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [8:0] p1_x,
    input  logic [8:0] p1_y,
    input  logic [8:0] p2_x,
    input  logic [8:0] p2_y,
    input  logic       redraw_all,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int unsigned       CntW    = (TOKEN_SZ > 1) ? $clog2(TOKEN_SZ) : 1;
    localparam logic [CntW-1:0]   LastIdx = CntW'(TOKEN_SZ - 1);
    localparam logic signed [9:0] TokSz   = 10'(TOKEN_SZ);

    typedef enum logic [1:0] {StIdle, StErase, StDraw} state_e;

    state_e state_q, state_d;

    // Last box drawn for each player (index 0 = P1, 1 = P2)
    logic [1:0][8:0] drawn_x_q, drawn_x_d;
    logic [1:0][8:0] drawn_y_q, drawn_y_d;
    logic [1:0]      drawn_valid_q, drawn_valid_d;
    // Requests that are not visible from the coordinates alone (redraw, repair)
    logic [1:0]      pend_q, pend_d;

    logic            sel_q, sel_d;
    logic [8:0]      tgt_x_q, tgt_x_d;
    logic [8:0]      tgt_y_q, tgt_y_d;
    logic [CntW-1:0] col_q, col_d;
    logic [CntW-1:0] row_q, row_d;
    logic [8:0]      x_hold_q, x_hold_d;
    logic [8:0]      y_hold_q, y_hold_d;
    logic [2:0]      colour_hold_q, colour_hold_d;
    logic            done_q, done_d;

    logic [1:0][8:0]  t_x, t_y;
    logic [1:0]       change;
    logic [1:0]       req;
    logic             any_req;
    logic             pick;
    logic             pick_moves;
    logic             last_pix;
    logic             oth;
    logic signed [9:0] dx, dy;
    logic             overlap;
    logic             plotting;
    logic [8:0]       base_x, base_y;
    logic [8:0]       pix_x, pix_y;
    logic [2:0]       pix_colour;

    // ------------------------------------------------------------------
    // Targets and change detection
    // ------------------------------------------------------------------
    always_comb begin
        t_x = {p2_x, p1_x};
        t_y = {p2_y + 9'(P2_Y_OFFSET), p1_y};
    end

    always_comb begin
        change = '0;
        for (int k = 0; k < 2; k++) begin
            change[k] = !drawn_valid_q[k] || (t_x[k] != drawn_x_q[k]) ||
                        (t_y[k] != drawn_y_q[k]);
        end
    end

    // Coordinate changes are evaluated live. After a draw updates the drawn
    // registers, a finished service no longer requests itself, and a target
    // that moved during the service still shows up as a change.
    assign req        = pend_q | change | {2{redraw_all}};
    assign any_req    = |req;
    assign pick       = ~req[0];
    assign pick_moves = drawn_valid_q[pick] &&
                        ((drawn_x_q[pick] != t_x[pick]) || (drawn_y_q[pick] != t_y[pick]));

    assign last_pix = (col_q == LastIdx) && (row_q == LastIdx);

    // Overlap between the box being erased and the other player's box
    assign oth     = ~sel_q;
    assign dx      = $signed({1'b0, drawn_x_q[sel_q]} - {1'b0, drawn_x_q[oth]});
    assign dy      = $signed({1'b0, drawn_y_q[sel_q]} - {1'b0, drawn_y_q[oth]});
    assign overlap = drawn_valid_q[oth] && (dx < TokSz) && (dx > -TokSz) &&
                     (dy < TokSz) && (dy > -TokSz);

    // ------------------------------------------------------------------
    // Pixel generation
    // ------------------------------------------------------------------
    assign plotting = (state_q != StIdle);

    always_comb begin
        if (state_q == StErase) begin
            base_x     = drawn_x_q[sel_q];
            base_y     = drawn_y_q[sel_q];
            pix_colour = BG_COLOUR;
        end else begin
            base_x     = tgt_x_q;
            base_y     = tgt_y_q;
            pix_colour = sel_q ? P2_COLOUR : P1_COLOUR;
        end
        pix_x = base_x + 9'(col_q);
        pix_y = base_y + 9'(row_q);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = pick_moves ? StErase : StDraw;
                end
            end
            StErase: begin
                if (last_pix) begin
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (last_pix) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        plot = plotting;
        busy = plotting;
        done = done_q;
        if (plotting) begin
            x      = pix_x;
            y      = pix_y;
            colour = pix_colour;
        end else begin
            x      = x_hold_q;
            y      = y_hold_q;
            colour = colour_hold_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state
    // ------------------------------------------------------------------
    always_comb begin
        drawn_x_d     = drawn_x_q;
        drawn_y_d     = drawn_y_q;
        drawn_valid_d = drawn_valid_q;
        pend_d        = pend_q | {2{redraw_all}};
        sel_d         = sel_q;
        tgt_x_d       = tgt_x_q;
        tgt_y_d       = tgt_y_q;
        col_d         = col_q;
        row_d         = row_q;
        x_hold_d      = x_hold_q;
        y_hold_d      = y_hold_q;
        colour_hold_d = colour_hold_q;
        done_d        = 1'b0;

        if (state_q == StIdle) begin
            if (any_req) begin
                // The target is frozen for the whole service
                sel_d        = pick;
                tgt_x_d      = t_x[pick];
                tgt_y_d      = t_y[pick];
                pend_d[pick] = 1'b0;
            end
        end else begin
            x_hold_d      = pix_x;
            y_hold_d      = pix_y;
            colour_hold_d = pix_colour;

            // Raster walk: column fastest, wrapping to zero after the last pixel
            if (col_q == LastIdx) begin
                col_d = '0;
                row_d = (row_q == LastIdx) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (state_q == StErase && last_pix && overlap) begin
                pend_d[oth] = 1'b1;
            end

            if (state_q == StDraw && last_pix) begin
                drawn_x_d[sel_q]     = tgt_x_q;
                drawn_y_d[sel_q]     = tgt_y_q;
                drawn_valid_d[sel_q] = 1'b1;
                done_d               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drawn_x_q     <= '0;
            drawn_y_q     <= '0;
            drawn_valid_q <= '0;
            pend_q        <= '0;
            sel_q         <= 1'b0;
            tgt_x_q       <= '0;
            tgt_y_q       <= '0;
            col_q         <= '0;
            row_q         <= '0;
            x_hold_q      <= '0;
            y_hold_q      <= '0;
            colour_hold_q <= '0;
            done_q        <= 1'b0;
        end else begin
            drawn_x_q     <= drawn_x_d;
            drawn_y_q     <= drawn_y_d;
            drawn_valid_q <= drawn_valid_d;
            pend_q        <= pend_d;
            sel_q         <= sel_d;
            tgt_x_q       <= tgt_x_d;
            tgt_y_q       <= tgt_y_d;
            col_q         <= col_d;
            row_q         <= row_d;
            x_hold_q      <= x_hold_d;
            y_hold_q      <= y_hold_d;
            colour_hold_q <= colour_hold_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_token_renderer.sv
// Testbench for token_renderer: scenario tasks compare the plotted pixel stream
// with a reference built from the token movement rules.

module tb_token_renderer;

    localparam int TS = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [8:0] p1_x = 9'd10;
    logic [8:0] p1_y = 9'd20;
    logic [8:0] p2_x = 9'd10;
    logic [8:0] p2_y = 9'd20;
    logic       redraw_all = 1'b0;
    logic [8:0] x, y;
    logic [2:0] colour;
    logic       plot, busy, done;

    always #5 clk = ~clk;

    token_renderer dut (
        .clk        (clk),
        .resetn     (resetn),
        .p1_x       (p1_x),
        .p1_y       (p1_y),
        .p2_x       (p2_x),
        .p2_y       (p2_y),
        .redraw_all (redraw_all),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: what is on screen per player
    bit m_valid[2];
    int m_x[2];
    int m_y[2];
    logic [20:0] exp_q[$];
    int exp_done;

    // Captured DUT behaviour
    logic [20:0] got_q[$];
    int got_done, first_busy, last_busy, first_plot, bad_cycles, timed_out;

    function automatic logic [20:0] pix(int px, int py, logic [2:0] c);
        return {9'(px % 512), 9'(py % 512), c};
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic push_box(int bx, int by, logic [2:0] c);
        for (int r = 0; r < TS; r++)
            for (int cc = 0; cc < TS; cc++)
                exp_q.push_back(pix(bx + cc, by + r, c));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_x[k] = 0;
            m_y[k] = 0;
        end
    endtask

    task automatic expect_clear();
        exp_q.delete();
        exp_done = 0;
    endtask

    // Serve every outstanding request with the inputs held at their current values
    task automatic model_settle(bit redraw);
        int tx[2], ty[2];
        bit pend[2], need[2];
        int k, j;
        tx[0] = int'(p1_x);
        ty[0] = int'(p1_y);
        tx[1] = int'(p2_x);
        ty[1] = (int'(p2_y) + 15) % 512;
        pend[0] = redraw;
        pend[1] = redraw;
        for (int it = 0; it < 16; it++) begin
            for (int q = 0; q < 2; q++)
                need[q] = pend[q] || !m_valid[q] || tx[q] != m_x[q] || ty[q] != m_y[q];
            if (!need[0] && !need[1]) break;
            k = need[0] ? 0 : 1;
            j = 1 - k;
            pend[k] = 0;
            if (m_valid[k] && (tx[k] != m_x[k] || ty[k] != m_y[k])) begin
                push_box(m_x[k], m_y[k], 3'b111);
                if (m_valid[j] && iabs(m_x[k] - m_x[j]) < TS && iabs(m_y[k] - m_y[j]) < TS)
                    pend[j] = 1;
            end
            push_box(tx[k], ty[k], (k == 0) ? 3'b001 : 3'b011);
            m_x[k] = tx[k];
            m_y[k] = ty[k];
            m_valid[k] = 1;
            exp_done++;
        end
    endtask

    // Record DUT output until it has been idle a few cycles.
    // inj_kind 1: set p1_x to inj_val at cycle inj_at; 2: pulse redraw_all there.
    task automatic capture(int inj_at, int inj_kind, int inj_val);
        int idle_run = 0;
        int cyc = 0;
        got_q.delete();
        got_done = 0;
        first_busy = -1;
        last_busy = -1;
        first_plot = -1;
        bad_cycles = 0;
        timed_out = 0;
        while (idle_run < 4 && cyc < 400) begin
            @(negedge clk);
            redraw_all = 1'b0;
            if (plot === 1'b1) begin
                got_q.push_back({x, y, colour});
                if (first_plot < 0) first_plot = cyc;
            end
            if (busy === 1'b1) begin
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (done === 1'b1) got_done++;
            if (plot !== busy || (done === 1'b1 && plot === 1'b1)) bad_cycles++;
            if (cyc == inj_at) begin
                if (inj_kind == 1) p1_x = 9'(inj_val);
                if (inj_kind == 2) redraw_all = 1'b1;
            end
            cyc++;
        end
        if (cyc >= 400) timed_out = 1;
    endtask

    function automatic int stream_diff();
        int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) return i;
        if (got_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [20:0] got_at(int i);
        return (i >= 0 && i < got_q.size()) ? got_q[i] : 21'hx;
    endfunction

    function automatic logic [20:0] exp_at(int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 21'hx;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        int d;
        resetn = 1'b0;
        p1_x = 9'd10; p1_y = 9'd20; p2_x = 9'd10; p2_y = 9'd20;
        repeat (3) @(negedge clk);
        checks++;
        if ({plot, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=000", {plot, busy, done});
        end
        checks++;
        if ({x, y, colour} !== 21'd0) begin
            failures++;
            $display("FAIL reset_pixel got=%h want=0", {x, y, colour});
        end
        model_reset();
        expect_clear();
        model_settle(0);
        resetn = 1'b1;
        capture(-1, 0, 0);
        checks++;
        d = stream_diff();
        if (d != -1 || timed_out) begin
            failures++;
            $display("FAIL first_draw_stream idx=%0d got=%h want=%h len=%0d/%0d", d,
                     got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        checks++;
        if (got_at(9) !== {9'd10, 9'd35, 3'b011}) begin
            failures++;
            $display("FAIL first_draw_p2_start got=%h want=%h", got_at(9), {9'd10, 9'd35, 3'b011});
        end
        checks++;
        if (got_done !== 2) begin
            failures++;
            $display("FAIL first_draw_done got=%0d want=2", got_done);
        end
        checks++;
        if (first_plot !== 0 || last_busy - first_busy + 1 !== 19) begin
            failures++;
            $display("FAIL first_draw_timing first=%0d span=%0d want first=0 span=19",
                     first_plot, last_busy - first_busy + 1);
        end
    endtask

    task automatic test_move();
        int d;
        p1_x = 9'd40;
        expect_clear();
        model_settle(0);
        capture(-1, 0, 0);
        checks++;
        d = stream_diff();
        if (d != -1 || timed_out) begin
            failures++;
            $display("FAIL move_stream idx=%0d got=%h want=%h len=%0d/%0d", d,
                     got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        checks++;
        if (first_plot !== 0 || got_at(0) !== {9'd10, 9'd20, 3'b111}) begin
            failures++;
            $display("FAIL move_first_pixel at=%0d got=%h want at=0 %h", first_plot, got_at(0),
                     {9'd10, 9'd20, 3'b111});
        end
        checks++;
        if (got_q.size() !== 18 || got_done !== 1 || bad_cycles !== 0) begin
            failures++;
            $display("FAIL move_counts plots=%0d done=%0d bad=%0d want 18/1/0", got_q.size(),
                     got_done, bad_cycles);
        end
    endtask

    task automatic test_both_move();
        int d;
        p1_x = 9'd100; p1_y = 9'd50;
        p2_x = 9'd200; p2_y = 9'd100;
        expect_clear();
        model_settle(0);
        capture(-1, 0, 0);
        checks++;
        d = stream_diff();
        if (d != -1 || timed_out) begin
            failures++;
            $display("FAIL both_stream idx=%0d got=%h want=%h len=%0d/%0d", d,
                     got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        checks++;
        if (got_done !== 2 || last_busy - first_busy + 1 !== 37) begin
            failures++;
            $display("FAIL both_timing done=%0d span=%0d want done=2 span=37", got_done,
                     last_busy - first_busy + 1);
        end
    endtask

    task automatic test_overlap();
        int d;
        p1_x = 9'd10; p1_y = 9'd34;
        p2_x = 9'd10; p2_y = 9'd20;
        expect_clear();
        model_settle(0);
        capture(-1, 0, 0);
        checks++;
        d = stream_diff();
        if (d != -1 || timed_out) begin
            failures++;
            $display("FAIL overlap_setup idx=%0d got=%h want=%h", d, got_at(d), exp_at(d));
        end
        p1_x = 9'd60;
        expect_clear();
        model_settle(0);
        capture(-1, 0, 0);
        checks++;
        d = stream_diff();
        if (d != -1 || timed_out) begin
            failures++;
            $display("FAIL overlap_stream idx=%0d got=%h want=%h len=%0d/%0d", d,
                     got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        checks++;
        if (got_q.size() !== 27 || got_done !== 2 ||
            got_at(26) !== {9'd12, 9'd37, 3'b011}) begin
            failures++;
            $display("FAIL overlap_repair plots=%0d done=%0d last=%h want 27/2/%h",
                     got_q.size(), got_done, got_at(26), {9'd12, 9'd37, 3'b011});
        end
    endtask

    task automatic test_mid_change();
        int d;
        p1_x = 9'd40; p1_y = 9'd200;
        expect_clear();
        model_settle(0);
        p1_x = 9'd70;
        model_settle(0);
        p1_x = 9'd40;
        capture(3, 1, 70);
        checks++;
        d = stream_diff();
        if (d != -1 || timed_out) begin
            failures++;
            $display("FAIL midchange_stream idx=%0d got=%h want=%h len=%0d/%0d", d,
                     got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        checks++;
        if (got_at(9) !== {9'd40, 9'd200, 3'b001} || got_done !== 2) begin
            failures++;
            $display("FAIL midchange_frozen pix9=%h done=%0d want %h/2", got_at(9), got_done,
                     {9'd40, 9'd200, 3'b001});
        end
    endtask

    task automatic test_redraw_during();
        int d;
        p1_y = 9'd150;
        expect_clear();
        model_settle(0);
        model_settle(1);
        capture(4, 2, 0);
        checks++;
        d = stream_diff();
        if (d != -1 || timed_out) begin
            failures++;
            $display("FAIL redraw_stream idx=%0d got=%h want=%h len=%0d/%0d", d,
                     got_at(d), exp_at(d), got_q.size(), exp_q.size());
        end
        checks++;
        if (got_done !== 3) begin
            failures++;
            $display("FAIL redraw_done got=%0d want=3", got_done);
        end
    endtask

    task automatic test_reset_mid();
        int d;
        int seen = 0;
        int n = 0;
        p1_x = 9'd300; p1_y = 9'd300;
        while (seen < 5 && n < 100) begin
            @(negedge clk);
            if (plot === 1'b1 && colour === 3'b001) seen++;
            n++;
        end
        checks++;
        if (seen < 5) begin
            failures++;
            $display("FAIL resetmid_reach draw_pixels=%0d want=5", seen);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({plot, busy, done} !== 3'b000 || {x, y, colour} !== 21'd0) begin
            failures++;
            $display("FAIL resetmid_async ctrl=%b pix=%h want 000/0", {plot, busy, done},
                     {x, y, colour});
        end
        @(negedge clk);
        model_reset();
        expect_clear();
        model_settle(0);
        resetn = 1'b1;
        capture(-1, 0, 0);
        checks++;
        d = stream_diff();
        if (d != -1 || timed_out || got_done !== 2) begin
            failures++;
            $display("FAIL resetmid_redraw idx=%0d got=%h want=%h done=%0d want=2", d,
                     got_at(d), exp_at(d), got_done);
        end
    endtask

    task automatic test_random();
        int d, base, mode;
        bit rd;
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 2))
                0: base = 0;
                1: base = 200;
                default: base = 506;
            endcase
            mode = int'($urandom_range(0, 3));
            rd = (mode == 3) || ($urandom_range(0, 4) == 0);
            if (mode == 0 || mode == 2) begin
                p1_x = 9'((base + int'($urandom_range(0, 7))) % 512);
                p1_y = 9'((base + int'($urandom_range(0, 7))) % 512);
            end
            if (mode == 1 || mode == 2) begin
                p2_x = 9'((base + int'($urandom_range(0, 7))) % 512);
                p2_y = 9'((base + int'($urandom_range(0, 7)) + 512 - 15) % 512);
            end
            expect_clear();
            model_settle(rd);
            redraw_all = rd;
            capture(-1, 0, 0);
            checks++;
            d = stream_diff();
            if (d != -1 || timed_out) begin
                failures++;
                $display("FAIL rand%0d_stream idx=%0d got=%h want=%h len=%0d/%0d", it, d,
                         got_at(d), exp_at(d), got_q.size(), exp_q.size());
            end
            checks++;
            if (got_done !== exp_done || bad_cycles !== 0) begin
                failures++;
                $display("FAIL rand%0d_done got=%0d want=%0d bad=%0d", it, got_done, exp_done,
                         bad_cycles);
            end
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_both_move();
        test_overlap();
        test_mid_change();
        test_redraw_during();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
